// File: rtl/cdc_req_sender_if.sv
// Handshake bundle for cdc_req_sender: the valid/ready word port plus the
// cross-domain req/ack pair and the completion/timeout pulses.
interface cdc_req_sender_if #(
   parameter int DW = 32
);
   logic          valid_i;
   logic [DW-1:0] data_i;
   logic          ready_o;
   logic          req_o;
   logic [DW-1:0] data_o;
   logic          ack_i;
   logic          done_o;
   logic          err_o;

   modport master (
      input  valid_i, data_i, ack_i,
      output ready_o, req_o, data_o, done_o, err_o
   );

   modport slave (
      output valid_i, data_i, ack_i,
      input  ready_o, req_o, data_o, done_o, err_o
   );
endinterface

// File: rtl/cdc_req_sender.sv
// Source side of a 4-phase req/ack handshake into another clock domain, with a
// synchronized ack, optional ack timeout and done/err completion pulses.
//
// state | meaning
// IDLE  | waiting for a word; ready_o high once any stale ack has cleared
// REQ   | req_o high, data_o held, waiting for synchronized ack (or timeout)
// REL   | req_o low, waiting for the receiver to drop ack
module cdc_req_sender #(
   parameter int DP      = 2,
   parameter int DW      = 32,
   parameter int TMO_CYC = 0
) (
   input logic               clk,
   input logic               rst,
   cdc_req_sender_if.master  bus
);

   localparam bit          TMO_EN   = (TMO_CYC != 0);
   localparam int          CW       = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DP-1:0]   sync_q;
   logic            ack_s;
   logic            req_q, req_d;
   logic [DW-1:0]   data_q, data_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ready;

   // ack_i is asynchronous; only the last flop of the chain reaches the FSM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[DP-2:0], bus.ack_i};
      end
   end

   assign ack_s = sync_q[DP-1];

   // Gated by rst so nothing is offered while the block is held in reset.
   assign ready = rst && (state_q == IDLE) && !ack_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         data_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i && ready) begin
               data_d  = bus.data_i;
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            // An ack arriving on the timeout cycle takes priority.
            if (ack_s) begin
               req_d   = 1'b0;
               done_d  = 1'b1;
               state_d = REL;
            end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               state_d = REL;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         REL: begin
            if (!ack_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   assign bus.ready_o = ready;
   assign bus.req_o   = req_q;
   assign bus.data_o  = data_q;
   assign bus.done_o  = done_q;
   assign bus.err_o   = err_q;

endmodule

// File: tb/tb_cdc_req_sender.sv
// Self-checking bench for cdc_req_sender: one instance without timeout, one
// with TMO_CYC=8; expectations come from edge arithmetic on the ack latency.
module tb_cdc_req_sender;
   localparam int DP = 2;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cdc_req_sender_if #(.DW(DW)) a ();
   cdc_req_sender_if #(.DW(DW)) b ();

   cdc_req_sender #(.DP(DP), .DW(DW), .TMO_CYC(0)) dut0 (.clk(clk), .rst(rst), .bus(a.master));
   cdc_req_sender #(.DP(DP), .DW(DW), .TMO_CYC(8)) dut8 (.clk(clk), .rst(rst), .bus(b.master));

   int n_chk = 0;
   int n_fail = 0;
   int done_a = 0, err_a = 0, done_b = 0, err_b = 0, both = 0;
   int exp_done_a = 0, exp_done_b = 0, exp_err_b = 0;

   always @(negedge clk) begin
      if (a.done_o === 1'b1) done_a++;
      if (a.err_o === 1'b1) err_a++;
      if (b.done_o === 1'b1) done_b++;
      if (b.err_o === 1'b1) err_b++;
      if ((a.done_o === 1'b1 && a.err_o === 1'b1) || (b.done_o === 1'b1 && b.err_o === 1'b1)) both++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transfer on the TMO_CYC=0 instance. Ack sampled at edge A
   // must show up as done at A+DP; ack dropped at edge B must give ready by B+DP+1.
   task automatic xfer(input logic [DW-1:0] word, input int ack_dly, input int rel_dly, input bit junk);
      for (int i = 0; i < 20 && a.ready_o !== 1'b1; i++) tick();
      n_chk++; if (a.ready_o !== 1'b1) begin n_fail++; $display("FAIL xfer_ready_start: got %0b want 1", a.ready_o); end
      a.valid_i = 1'b1;
      a.data_i  = word;
      tick();
      n_chk++; if (a.req_o !== 1'b1 || a.data_o !== word) begin n_fail++; $display("FAIL xfer_accept: req %0b data %h want req 1 data %h", a.req_o, a.data_o, word); end
      if (junk) a.data_i = word ^ 32'h1; else a.valid_i = 1'b0;
      for (int k = 0; k < ack_dly; k++) begin
         tick();
         n_chk++; if (a.req_o !== 1'b1 || a.data_o !== word || a.done_o !== 1'b0) begin n_fail++; $display("FAIL xfer_hold: req %0b data %h done %0b want 1 %h 0", a.req_o, a.data_o, a.done_o, word); end
         if (junk) a.data_i = DW'(((k + 1) % 3) + 1);
      end
      a.ack_i = 1'b1;
      for (int k = 0; k < DP; k++) begin
         tick();
         n_chk++; if (a.req_o !== 1'b1 || a.done_o !== 1'b0 || a.data_o !== word) begin n_fail++; $display("FAIL xfer_ack_wait: req %0b done %0b data %h want 1 0 %h", a.req_o, a.done_o, a.data_o, word); end
      end
      tick();
      n_chk++; if (a.req_o !== 1'b0 || a.done_o !== 1'b1 || a.data_o !== word) begin n_fail++; $display("FAIL xfer_done: req %0b done %0b data %h want 0 1 %h", a.req_o, a.done_o, a.data_o, word); end
      exp_done_a++;
      a.valid_i = 1'b0;
      tick();
      n_chk++; if (a.done_o !== 1'b0 || a.ready_o !== 1'b0) begin n_fail++; $display("FAIL xfer_done_pulse: done %0b ready %0b want 0 0", a.done_o, a.ready_o); end
      for (int k = 0; k < rel_dly; k++) tick();
      a.ack_i = 1'b0;
      for (int k = 0; k < DP; k++) tick();
      n_chk++; if (a.ready_o !== 1'b0) begin n_fail++; $display("FAIL xfer_rel_early: ready %0b want 0", a.ready_o); end
      tick();
      tick();
      n_chk++; if (a.ready_o !== 1'b1 || a.data_o !== word) begin n_fail++; $display("FAIL xfer_rel_ready: ready %0b data %h want 1 %h", a.ready_o, a.data_o, word); end
   endtask

   task automatic test_reset();
      a.valid_i = 1'b1; a.ack_i = 1'b1; a.data_i = $urandom;
      b.valid_i = 1'b1; b.ack_i = 1'b1; b.data_i = $urandom;
      #2 rst = 1'b0;
      repeat (3) tick();
      n_chk++; if (a.req_o !== 1'b0 || a.data_o !== '0) begin n_fail++; $display("FAIL reset_req_data: req %0b data %h want 0 0", a.req_o, a.data_o); end
      n_chk++; if (a.done_o !== 1'b0 || a.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done %0b err %0b want 0 0", a.done_o, a.err_o); end
      n_chk++; if (a.ready_o !== 1'b0 || b.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: a %0b b %0b want 0 0", a.ready_o, b.ready_o); end
      n_chk++; if (b.req_o !== 1'b0 || b.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_b: req %0b err %0b want 0 0", b.req_o, b.err_o); end
      a.valid_i = 1'b0; a.ack_i = 1'b0;
      b.valid_i = 1'b0; b.ack_i = 1'b0;
      @(negedge clk) rst = 1'b1;
      tick();
      tick();
      n_chk++; if (a.ready_o !== 1'b1 || b.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: a %0b b %0b want 1 1", a.ready_o, b.ready_o); end
   endtask

   task automatic test_basic();
      xfer(32'hDEADBEEF, 4, 1, 1'b0);
   endtask

   task automatic test_back_pressure();
      xfer(32'h0000_0001, 5, 2, 1'b1);
   endtask

   task automatic test_stale_ack();
      a.ack_i = 1'b1;
      repeat (DP) tick();
      n_chk++; if (a.ready_o !== 1'b0) begin n_fail++; $display("FAIL stale_ready: got %0b want 0", a.ready_o); end
      a.valid_i = 1'b1; a.data_i = $urandom;
      repeat (3) tick();
      n_chk++; if (a.req_o !== 1'b0 || a.done_o !== 1'b0) begin n_fail++; $display("FAIL stale_ignored: req %0b done %0b want 0 0", a.req_o, a.done_o); end
      a.valid_i = 1'b0; a.ack_i = 1'b0;
      repeat (DP + 1) tick();
      n_chk++; if (a.ready_o !== 1'b1) begin n_fail++; $display("FAIL stale_recover: got %0b want 1", a.ready_o); end
   endtask

   task automatic test_random();
      logic [DW-1:0] w;
      for (int n = 0; n < 8; n++) begin
         w = $urandom;
         xfer(w, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_timeout();
      logic [DW-1:0] w;
      w = $urandom;
      for (int i = 0; i < 20 && b.ready_o !== 1'b1; i++) tick();
      b.valid_i = 1'b1; b.data_i = w;
      tick();
      n_chk++; if (b.req_o !== 1'b1 || b.data_o !== w) begin n_fail++; $display("FAIL tmo_accept: req %0b data %h want 1 %h", b.req_o, b.data_o, w); end
      b.valid_i = 1'b0;
      for (int k = 1; k < 8; k++) begin
         tick();
         n_chk++; if (b.err_o !== 1'b0 || b.req_o !== 1'b1) begin n_fail++; $display("FAIL tmo_early: cycle %0d err %0b req %0b want 0 1", k, b.err_o, b.req_o); end
      end
      tick();
      n_chk++; if (b.err_o !== 1'b1 || b.req_o !== 1'b0 || b.done_o !== 1'b0) begin n_fail++; $display("FAIL tmo_fire: err %0b req %0b done %0b want 1 0 0", b.err_o, b.req_o, b.done_o); end
      exp_err_b++;
      tick();
      n_chk++; if (b.err_o !== 1'b0 || b.ready_o !== 1'b1 || b.data_o !== w) begin n_fail++; $display("FAIL tmo_after: err %0b ready %0b data %h want 0 1 %h", b.err_o, b.ready_o, b.data_o, w); end
   endtask

   task automatic test_race();
      b.valid_i = 1'b1; b.data_i = $urandom;
      tick();
      b.valid_i = 1'b0;
      repeat (5) tick();
      b.ack_i = 1'b1;
      tick();
      tick();
      n_chk++; if (b.req_o !== 1'b1 || b.err_o !== 1'b0) begin n_fail++; $display("FAIL race_pending: req %0b err %0b want 1 0", b.req_o, b.err_o); end
      tick();
      n_chk++; if (b.done_o !== 1'b1 || b.err_o !== 1'b0 || b.req_o !== 1'b0) begin n_fail++; $display("FAIL race_ack_wins: done %0b err %0b req %0b want 1 0 0", b.done_o, b.err_o, b.req_o); end
      exp_done_b++;
      b.ack_i = 1'b0;
      for (int i = 0; i < 20 && b.ready_o !== 1'b1; i++) tick();
      n_chk++; if (b.ready_o !== 1'b1) begin n_fail++; $display("FAIL race_recover: ready %0b want 1", b.ready_o); end
   endtask

   task automatic test_reset_mid_req();
      a.valid_i = 1'b1; a.data_i = $urandom;
      tick();
      a.valid_i = 1'b0;
      n_chk++; if (a.req_o !== 1'b1) begin n_fail++; $display("FAIL midrst_req_up: got %0b want 1", a.req_o); end
      #2 rst = 1'b0;
      #1;
      n_chk++; if (a.req_o !== 1'b0 || a.data_o !== '0) begin n_fail++; $display("FAIL midrst_async: req %0b data %h want 0 0", a.req_o, a.data_o); end
      @(negedge clk) rst = 1'b1;
      xfer(32'hA5A5_5A5A, 2, 0, 1'b0);
   endtask

   task automatic test_totals();
      n_chk++; if (done_a !== exp_done_a || err_a !== 0) begin n_fail++; $display("FAIL totals_a: done %0d err %0d want %0d 0", done_a, err_a, exp_done_a); end
      n_chk++; if (done_b !== exp_done_b || err_b !== exp_err_b) begin n_fail++; $display("FAIL totals_b: done %0d err %0d want %0d %0d", done_b, err_b, exp_done_b, exp_err_b); end
      n_chk++; if (both !== 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d want 0", both); end
   endtask

   initial begin
      a.valid_i = 1'b0; a.data_i = '0; a.ack_i = 1'b0;
      b.valid_i = 1'b0; b.data_i = '0; b.ack_i = 1'b0;
      test_reset();
      test_basic();
      test_back_pressure();
      test_stale_ack();
      test_random();
      test_timeout();
      test_race();
      test_reset_mid_req();
      repeat (3) tick();
      test_totals();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
